// File: rtl/pulse_meter.sv
// pulse_meter: measures period and high time of an asynchronous pulse train,
// in clk cycles.
//
// Parameters:
//   CNT_BITS  width of the counters and of period/high_time (4..32)
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   enable     high = measure; low = return to IDLE (outputs held, no_signal cleared)
//   sig_in     asynchronous pulse input
//   period     cycles between the last two detected rising edges (saturating)
//   high_time  cycles the synchronised input was high within that period
//   valid      one-cycle strobe when period/high_time/overflow update
//   overflow   last measurement saturated in either counter
//   no_signal  no rising edge for 2^CNT_BITS-1 cycles while measuring
module pulse_meter #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sig_in,
  output logic [CNT_BITS-1:0] period,
  output logic [CNT_BITS-1:0] high_time,
  output logic                valid,
  output logic                overflow,
  output logic                no_signal
);

  localparam logic [CNT_BITS-1:0] MAX = '1;
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t              state;
  logic                sig_m;
  logic                sig_s;
  logic                sig_d;
  logic                rise;
  logic [CNT_BITS-1:0] pcnt;
  logic [CNT_BITS-1:0] hcnt;
  logic [CNT_BITS-1:0] pcnt_inc;
  logic [CNT_BITS-1:0] hcnt_inc;

  // Two-flop synchroniser plus one delay stage for edge detection.
  // Runs independently of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_m <= 1'b0;
      sig_s <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_m <= sig_in;
      sig_s <= sig_m;
      sig_d <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;

  // Saturating increments: counters stick at MAX and never wrap.
  assign pcnt_inc = (pcnt == MAX) ? MAX : pcnt + ONE;
  assign hcnt_inc = (hcnt == MAX) ? MAX : hcnt + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      no_signal <= 1'b0;
    end else if (!enable) begin
      // Measurement results are held; only the live state is cleared.
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only arms the counters; there is no prior edge to
          // measure against, so no strobe.
          if (rise) begin
            state <= MEASURE;
            pcnt  <= ONE;
            hcnt  <= ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period    <= pcnt;
            high_time <= hcnt;
            overflow  <= (pcnt == MAX) | (hcnt == MAX);
            valid     <= 1'b1;
            no_signal <= 1'b0;
            pcnt      <= ONE;
            hcnt      <= ONE;
          end else begin
            pcnt <= pcnt_inc;
            if (sig_s) hcnt <= hcnt_inc;
            // Flag in the same cycle the period counter arrives at MAX.
            if (pcnt_inc == MAX) no_signal <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Testbench for pulse_meter: two instances (CNT_BITS=16 and 8) share one
// stimulus stream. A timestamp/history model predicts every output each cycle;
// literal checks pin the model on the hand-worked scenarios.
module tb_pulse_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sig_in;
  logic [15:0] period16, high16;
  logic        valid16, ovf16, nos16;
  logic [7:0]  period8, high8;
  logic        valid8, ovf8, nos8;

  int n_assert = 0;
  int n_fail   = 0;
  int vcount16 = 0;

  always #5 clk = ~clk;

  pulse_meter #(.CNT_BITS(16)) dut16 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .period(period16), .high_time(high16), .valid(valid16),
    .overflow(ovf16), .no_signal(nos16)
  );

  pulse_meter #(.CNT_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in),
    .period(period8), .high_time(high8), .valid(valid8),
    .overflow(ovf8), .no_signal(nos8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // in_hist[e] = sig_in sampled at clock edge e. The synchronised signal during
  // the interval after edge m is the sample from edge m-1. A rise at interval r
  // is timestamped r; period = distance between rise timestamps, high time =
  // number of high synchronised intervals from one rise up to the next.
  localparam int HIST = 65536;
  bit     in_hist [0:HIST-1];
  longint n = 3;
  longint mx    [2] = '{65535, 255};
  bit     meas  [2];
  longint last  [2];
  longint mper  [2];
  longint mhigh [2];
  bit     mval  [2];
  bit     movf  [2];
  bit     mnos  [2];

  task automatic model_step(input int i);
    bit     ss, sd;
    longint p, h;
    ss = in_hist[n-2];
    sd = in_hist[n-3];
    if (!enable) begin
      meas[i] = 1'b0;
      mval[i] = 1'b0;
      mnos[i] = 1'b0;
    end else if (ss && !sd) begin
      mval[i] = 1'b0;
      if (meas[i]) begin
        p = (n - 1) - last[i];
        h = 0;
        for (longint k = last[i]; k <= n - 2; k++) h += longint'(in_hist[k-1]);
        mper[i]  = (p < mx[i]) ? p : mx[i];
        mhigh[i] = (h < mx[i]) ? h : mx[i];
        movf[i]  = (p >= mx[i]) || (h >= mx[i]);
        mval[i]  = 1'b1;
        mnos[i]  = 1'b0;
      end
      meas[i] = 1'b1;
      last[i] = n - 1;
    end else begin
      mval[i] = 1'b0;
      if (meas[i] && (n - last[i]) >= mx[i]) mnos[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    n++;
    in_hist[n] = sig_in;
    if (rst) begin
      in_hist[n]   = 1'b0;
      in_hist[n-1] = 1'b0;
      in_hist[n-2] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        meas[i] = 1'b0; mper[i] = 0; mhigh[i] = 0;
        mval[i] = 1'b0; movf[i] = 1'b0; mnos[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
    #1;
    chk("period16",    period16, mper[0]);
    chk("high16",      high16,   mhigh[0]);
    chk("valid16",     valid16,  mval[0]);
    chk("overflow16",  ovf16,    movf[0]);
    chk("no_signal16", nos16,    mnos[0]);
    chk("period8",     period8,  mper[1]);
    chk("high8",       high8,    mhigh[1]);
    chk("valid8",      valid8,   mval[1]);
    chk("overflow8",   ovf8,     movf[1]);
    chk("no_signal8",  nos8,     mnos[1]);
    if (valid16) vcount16++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      sig_in = 1'b1; cyc(hi);
      sig_in = 1'b0; cyc(lo);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_period",    period16, 0);
    chk("reset_high",      high16,   0);
    chk("reset_valid",     valid16,  0);
    chk("reset_no_signal", nos16,    0);

    // 50/50 square wave: 5 rises, first one only arms.
    enable = 1'b1; vcount16 = 0;
    wave(50, 50, 5);
    chk("square_valids",   vcount16, 4);
    chk("square_period",   period16, 100);
    chk("square_high",     high16,   50);
    chk("square_overflow", ovf16,    0);
    chk("square_nosig",    nos16,    0);

    // 1 high, 2 low.
    vcount16 = 0;
    wave(1, 2, 10);
    chk("fast_valids", vcount16, 10);
    chk("fast_period", period16, 3);
    chk("fast_high",   high16,   1);

    // Period 300 / 10 high: saturates the 8-bit instance.
    wave(10, 290, 2);
    sig_in = 1'b1; cyc(10);
    sig_in = 1'b0; cyc(245);
    chk("nosig8_before", nos8, 0);
    cyc(2);
    chk("nosig8_after",  nos8, 1);
    cyc(43);
    chk("sat8_period",   period8,  255);
    chk("sat8_high",     high8,    10);
    chk("sat8_overflow", ovf8,     1);
    chk("wide16_period", period16, 300);
    chk("wide16_high",   high16,   10);
    chk("wide16_ovf",    ovf16,    0);
    chk("wide16_nosig",  nos16,    0);
    wave(50, 50, 1);
    chk("sat8_nosig_cleared", nos8, 0);

    // Enable drop while the input keeps toggling.
    wave(50, 50, 1);
    enable = 1'b0; vcount16 = 0;
    wave(5, 5, 2);
    chk("dis_valids", vcount16, 0);
    chk("dis_period", period16, 100);
    chk("dis_high",   high16,   50);
    chk("dis_nosig",  nos16,    0);
    enable = 1'b1; vcount16 = 0;
    wave(50, 50, 3);
    chk("reen_valids", vcount16, 2);
    chk("reen_period", period16, 100);
    chk("reen_high",   high16,   50);

    // Reset mid-period (during the low phase).
    sig_in = 1'b1; cyc(50);
    sig_in = 1'b0; cyc(20);
    rst = 1'b1;
    #1;
    chk("rst_period16", period16, 0);
    chk("rst_high16",   high16,   0);
    chk("rst_period8",  period8,  0);
    chk("rst_valid16",  valid16,  0);
    chk("rst_ovf8",     ovf8,     0);
    cyc(1);
    rst = 1'b0;
    cyc(29);
    vcount16 = 0;
    wave(50, 50, 2);
    chk("post_rst_valids", vcount16, 1);
    chk("post_rst_period", period16, 100);
    chk("post_rst_high",   high16,   50);

    // Switch from 100-cycle to 40-cycle period on a rise boundary.
    wave(20, 20, 3);
    chk("switch_period", period16, 40);
    chk("switch_high",   high16,   20);

    // Randomised segments with occasional enable drops and resets.
    for (int s = 0; s < 60; s++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1; cyc(1); rst = 1'b0;
      end
      wave(int'($urandom_range(1, 25)), int'($urandom_range(1, 40)), 1);
    end

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
